// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: default widths/depth and the
// per-cycle queue operation encoding used by the occupancy update.
package fetch_queue_pkg;

  localparam int DEF_XLEN          = 64;
  localparam int DEF_ILEN          = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  // Bit 1 = enqueue fires, bit 0 = dequeue fires.
  typedef enum logic [1:0] {
    FQ_OP_IDLE = 2'b00,
    FQ_OP_POP  = 2'b01,
    FQ_OP_PUSH = 2'b10,
    FQ_OP_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/fq_storage.sv
// Register array holding queued {pc, inst} entries.
// One synchronous write port, one asynchronous read port, no reset:
// validity is tracked entirely by the pointer/count logic in fetch_queue.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write the entry presented on an accepted enqueue.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Head entry is read combinationally so it is visible the cycle after it is written.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue. Buffers {pc, inst} pairs so a decode
// stall does not immediately stall fetch. A taken-branch flush from ID
// empties the queue in one cycle. No bypass: an entry written in cycle N
// reaches the output in cycle N+1 at the earliest, and a full queue never
// accepts, even when the head is being consumed in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int XLEN  = DEF_XLEN,
  parameter int ILEN  = DEF_ILEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [ILEN-1:0]            in_inst_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [ILEN-1:0]            out_inst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = XLEN + ILEN;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             enq_s;
  logic             deq_s;
  fq_op_e           op_s;
  logic [ENT_W-1:0] rdata_s;

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_storage (
    .clock (clock),
    .we    (enq_s),
    .waddr (tail_r),
    .wdata ({in_pc_i, in_inst_i}),
    .raddr (head_r),
    .rdata (rdata_s)
  );

  // Handshake decode; flush suppresses both same-cycle transfers.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    enq_s       = 1'b0;
    deq_s       = 1'b0;
    in_ready_o  = !reset && (count_r != FULL_CNT);
    out_valid_o = (count_r != CNT_ZERO);
    enq_s       = in_valid_i && in_ready_o && !flush_i;
    deq_s       = out_valid_o && out_ready_i && !flush_i;
    op_s        = fq_op_e'({enq_s, deq_s});
  end

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      FQ_OP_PUSH: count_nxt_s = count_r + CNT_ONE;
      FQ_OP_POP:  count_nxt_s = count_r - CNT_ONE;
      FQ_OP_BOTH: count_nxt_s = count_r;
      FQ_OP_IDLE: count_nxt_s = count_r;
      default:    count_nxt_s = count_r;
    endcase
  end

  // Pointer and count state; reset and flush both discard every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush_i) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (deq_s) begin
        head_r <= head_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Head entry masked to zero when the queue is empty, so stale storage never leaks.
  always_comb begin
    out_pc_o   = {XLEN{1'b0}};
    out_inst_o = {ILEN{1'b0}};
    if (out_valid_o) begin
      out_pc_o   = rdata_s[ENT_W-1:ILEN];
      out_inst_o = rdata_s[ILEN-1:0];
    end else begin
      out_pc_o   = {XLEN{1'b0}};
      out_inst_o = {ILEN{1'b0}};
    end
  end

  // Occupancy is reported straight from the count register.
  always_comb begin
    count_o = count_r;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for fill/drain/latency,
// plus hand-written sequences for wrap-around concurrency, full+pop,
// flush priority and reset mid-operation.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_pc_i;
  logic [31:0] in_inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic [2:0]  count_o;

  int n_cmp;
  int n_err;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs [16];

  fetch_queue #(.DEPTH(4), .XLEN(64), .ILEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_pc_i     (in_pc_i),
    .in_inst_i   (in_inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pc_o    (out_pc_o),
    .out_inst_o  (out_inst_o),
    .count_o     (count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                              input logic rdy, input logic er, input logic ev,
                              input logic [63:0] epc, input logic [31:0] einst,
                              input logic [2:0] ec);
    vec_t t;
    t.v = v; t.pc = pc; t.inst = inst; t.rdy = rdy;
    t.e_ready = er; t.e_valid = ev; t.e_pc = epc; t.e_inst = einst; t.e_count = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [63:0] pc,
                       input logic [31:0] inst, input logic rdy);
    reset       = r;
    flush_i     = f;
    in_valid_i  = v;
    in_pc_i     = pc;
    in_inst_i   = inst;
    out_ready_i = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, rdy);
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] inst);
    drive(1'b0, 1'b0, 1'b1, pc, inst, 1'b0);
    tick();
  endtask

  // Advance from just after one falling edge to the next falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [63:0] cpc(input int k);
    return 64'h0000_0000_8000_0400 + 64'(4 * k);
  endfunction

  function automatic logic [31:0] cinst(input int k);
    return 32'h0000_1000 + 32'(k);
  endfunction

  initial begin
    logic [63:0] p0, p1, p2, p3, p4;
    logic [31:0] i0, i1, i2, i3, i4;
    n_cmp = 0;
    n_err = 0;
    p0 = 64'h8000_0000; p1 = 64'h8000_0004; p2 = 64'h8000_0008;
    p3 = 64'h8000_000C; p4 = 64'h8000_0010;
    i0 = 32'h0000_0013; i1 = 32'h0010_0093; i2 = 32'h0020_0113;
    i3 = 32'h0030_0193; i4 = 32'h0040_0213;

    vecs[0]  = mk(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 3'd0);
    vecs[1]  = mk(1'b1, p0,    i0,    1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 3'd0);
    vecs[2]  = mk(1'b1, p1,    i1,    1'b0, 1'b1, 1'b1, p0,    i0,    3'd1);
    vecs[3]  = mk(1'b1, p2,    i2,    1'b0, 1'b1, 1'b1, p0,    i0,    3'd2);
    vecs[4]  = mk(1'b1, p3,    i3,    1'b0, 1'b1, 1'b1, p0,    i0,    3'd3);
    vecs[5]  = mk(1'b1, p4,    i4,    1'b0, 1'b0, 1'b1, p0,    i0,    3'd4);
    vecs[6]  = mk(1'b1, p4,    i4,    1'b0, 1'b0, 1'b1, p0,    i0,    3'd4);
    vecs[7]  = mk(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b1, p0,    i0,    3'd4);
    vecs[8]  = mk(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1, p1,    i1,    3'd3);
    vecs[9]  = mk(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1, p2,    i2,    3'd2);
    vecs[10] = mk(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1, p3,    i3,    3'd1);
    vecs[11] = mk(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0, 3'd0);
    vecs[12] = mk(1'b1, p4,    i4,    1'b1, 1'b1, 1'b0, 64'h0, 32'h0, 3'd0);
    vecs[13] = mk(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b1, p4,    i4,    3'd1);
    vecs[14] = mk(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1, p4,    i4,    3'd1);
    vecs[15] = mk(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 64'h0, 32'h0, 3'd0);

    // Reset for two edges.
    drive(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
    tick();
    #1;
    chk("reset.in_ready", 64'(in_ready_o), 64'h0);
    tick();
    idle(1'b0);
    #1;
    chk("post_reset.valid", 64'(out_valid_o), 64'h0);
    chk("post_reset.ready", 64'(in_ready_o), 64'h1);
    chk("post_reset.count", 64'(count_o), 64'h0);
    chk("post_reset.pc", out_pc_o, 64'h0);
    chk("post_reset.inst", 64'(out_inst_o), 64'h0);

    // Vector table: fill, reject when full, drain in order, pop on empty, latency.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d.ready", i), 64'(in_ready_o),  64'(vecs[i].e_ready));
      chk($sformatf("vec%0d.valid", i), 64'(out_valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.pc", i),    out_pc_o,         vecs[i].e_pc);
      chk($sformatf("vec%0d.inst", i),  64'(out_inst_o),  64'(vecs[i].e_inst));
      chk($sformatf("vec%0d.count", i), 64'(count_o),     64'(vecs[i].e_count));
      tick();
    end

    // Concurrency: hold count at 2 with push+pop for 10 cycles, pointers wrap.
    push(cpc(0), cinst(0));
    push(cpc(1), cinst(1));
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b0, 1'b1, cpc(j + 2), cinst(j + 2), 1'b1);
      #1;
      chk($sformatf("conc%0d.count", j), 64'(count_o), 64'h2);
      chk($sformatf("conc%0d.ready", j), 64'(in_ready_o), 64'h1);
      chk($sformatf("conc%0d.pc", j), out_pc_o, cpc(j));
      chk($sformatf("conc%0d.inst", j), 64'(out_inst_o), 64'(cinst(j)));
      tick();
    end
    for (int j = 10; j < 12; j++) begin
      idle(1'b1);
      #1;
      chk($sformatf("conc_drain%0d.pc", j), out_pc_o, cpc(j));
      tick();
    end
    idle(1'b0);
    #1;
    chk("conc_end.count", 64'(count_o), 64'h0);

    // Full plus dequeue: no pass-through, count drops to 3.
    for (int k = 0; k < 4; k++) push(64'h8000_0500 + 64'(4 * k), 32'h0000_2000 + 32'(k));
    drive(1'b0, 1'b0, 1'b1, 64'h8000_0600, 32'h0000_2FFF, 1'b1);
    #1;
    chk("fullpop.ready", 64'(in_ready_o), 64'h0);
    chk("fullpop.count", 64'(count_o), 64'h4);
    chk("fullpop.pc", out_pc_o, 64'h8000_0500);
    tick();
    idle(1'b0);
    #1;
    chk("fullpop_after.count", 64'(count_o), 64'h3);
    for (int k = 1; k < 4; k++) begin
      idle(1'b1);
      #1;
      chk($sformatf("fullpop_drain%0d.pc", k), out_pc_o, 64'h8000_0500 + 64'(4 * k));
      tick();
    end
    idle(1'b0);
    #1;
    chk("fullpop_end.valid", 64'(out_valid_o), 64'h0);

    // Flush wins over same-cycle enqueue and dequeue.
    for (int k = 0; k < 3; k++) push(64'h8000_0700 + 64'(4 * k), 32'h0000_3000 + 32'(k));
    drive(1'b0, 1'b1, 1'b1, 64'h8000_0800, 32'h0000_3FFF, 1'b1);
    #1;
    chk("flush.count_before", 64'(count_o), 64'h3);
    tick();
    idle(1'b0);
    #1;
    chk("flush.count", 64'(count_o), 64'h0);
    chk("flush.valid", 64'(out_valid_o), 64'h0);
    chk("flush.pc", out_pc_o, 64'h0);
    push(64'h8000_0100, 32'h0050_0293);
    idle(1'b0);
    #1;
    chk("flush_next.valid", 64'(out_valid_o), 64'h1);
    chk("flush_next.pc", out_pc_o, 64'h8000_0100);
    chk("flush_next.inst", 64'(out_inst_o), 64'h0050_0293);
    chk("flush_next.count", 64'(count_o), 64'h1);
    idle(1'b1);
    tick();
    idle(1'b0);
    #1;
    chk("flush_pop.count", 64'(count_o), 64'h0);

    // Reset mid-operation discards entries and blocks the same-cycle enqueue.
    push(64'h8000_0900, 32'h0000_4000);
    push(64'h8000_0904, 32'h0000_4001);
    drive(1'b1, 1'b0, 1'b1, 64'h8000_0908, 32'h0000_4002, 1'b0);
    #1;
    chk("midreset.ready", 64'(in_ready_o), 64'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      #1;
      chk($sformatf("midreset_after%0d.count", i), 64'(count_o), 64'h0);
      chk($sformatf("midreset_after%0d.valid", i), 64'(out_valid_o), 64'h0);
      chk($sformatf("midreset_after%0d.pc", i), out_pc_o, 64'h0);
      tick();
    end
    push(64'h8000_0A00, 32'h0060_0313);
    idle(1'b0);
    #1;
    chk("midreset_new.pc", out_pc_o, 64'h8000_0A00);
    chk("midreset_new.count", 64'(count_o), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small synchronous FIFO between instruction fetch and decode; buffers {pc, inst} pairs so decode stalls do not freeze fetch immediately.
- Enqueue side is fed by the fetch stage (pc, inst per cycle); dequeue side feeds ID.
- Flushed in one cycle when ID resolves a taken branch, discarding wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 64, pc width.
- ILEN, 32, instruction width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  taken branch from ID; empties the queue.
- in_valid_i  in  1  fetch presents a valid entry.
- in_ready_o  out  1  queue can accept an entry this cycle.
- in_pc_i  in  XLEN  pc of the fetched instruction.
- in_inst_i  in  ILEN  fetched instruction word.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  ID consumes the head entry this cycle.
- out_pc_o  out  XLEN  head pc; 0 when out_valid_o=0.
- out_inst_o  out  ILEN  head instruction; 0 when out_valid_o=0.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State: storage array of DEPTH x (XLEN+ILEN); head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; count register 0..DEPTH.
- Enqueue fires when in_valid_i && in_ready_o && !flush_i; writes at tail, tail+1.
- Dequeue fires when out_valid_o && out_ready_i && !flush_i; head+1.
- in_ready_o = !reset && (count != DEPTH). There is no pass-through when full: a simultaneous dequeue does not raise in_ready_o in that cycle.
- out_valid_o = (count != 0), registered state only. There is no bypass, so an entry written in cycle N is visible at the output in cycle N+1 at the earliest (1-cycle latency).
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count unchanged, both pointers advance.
- flush_i (highest priority after reset):
  - head, tail and count go to 0 on the next edge.
  - The same-cycle enqueue and dequeue are both ignored.
  - out_valid_o=0 from the next cycle.
  - Storage contents are not cleared.
- reset: head=tail=count=0 on the next edge.
  - During any reset cycle, in_ready_o=0.
  - out_valid_o follows count, so it reads 0 from the cycle after the first reset edge.
  - Reset mid-operation discards all entries exactly like flush.
  - Storage array is not reset.
- Output values after reset: out_valid_o=0, in_ready_o=1 (once reset deasserts), out_pc_o=0, out_inst_o=0, count_o=0.
- out_pc_o and out_inst_o are masked to 0 whenever out_valid_o=0.
- in_valid_i while full: entry is not accepted; fetch must hold it (fetch stalls its pc).
- out_ready_i while empty: no effect; head does not move and count does not underflow.
- Inputs are sampled only on handshake; in_pc_i/in_inst_i may change freely when not accepted.

Decomposition:
- Shared defines header (existing global include) gains XLEN=64, ILEN=32 and the FETCH_QUEUE_DEPTH default. PMEM_START stays where it already lives.
- One natural sub-module: fq_storage, a DEPTH-entry register array with one write port (we, waddr, wdata) and one async read port (raddr → rdata), no reset.
- Pointer/count control and handshake logic stay in fetch_queue.

Test Plan:
- Reset, then idle: after reset deasserts → out_valid_o=0, in_ready_o=1, count_o=0, out_pc_o=0, out_inst_o=0.
- Fill, then drain in order:
  - Enqueue pc 0x80000000/0x80000004/0x80000008/0x8000000C with insts 0x00000013, 0x00100093, 0x00200113, 0x00300193 and out_ready_i=0.
  - Expect count_o=4 and in_ready_o=0; a fifth enqueue (pc 0x80000010) is rejected.
  - Raise out_ready_i → entries appear in order, one per cycle, then out_valid_o=0.
- Latency and concurrency:
  - Single enqueue into an empty queue in cycle N → out_valid_o=1 in N+1, not N.
  - With count=2, simultaneous enqueue and dequeue for 10 cycles → count_o stays 2 and pointers wrap past DEPTH with no loss or reordering.
- Full plus dequeue: with count=4, in_valid_i=1 and out_ready_i=1 in the same cycle → in_ready_o=0, no enqueue, count_o=3 next cycle.
- Flush priority: with count=3, assert flush_i together with in_valid_i and out_ready_i → next cycle count_o=0 and out_valid_o=0. A subsequent enqueue of pc 0x80000100 is the next output.
- Reset mid-operation: with count=2, assert reset for one cycle while in_valid_i=1 → in_ready_o=0 during reset, count_o=0 after, and no stale entry ever appears on the output.
